exe_stage: RTL

Execute stage of the 5-stage ARM pipeline: the consumer end of the ID/EXE pipeline register. It generates the second operand (Val2), runs the ALU, owns the NZCV status register that feeds back to the ID stage, and drives the branch-taken/target pair to the IF stage. Its EXE/MEM pipeline register hands results to the memory stage.

---
 rtl/arm_pkg.sv | 29 ++
 rtl/exe_alu.sv | 50 +++++
 rtl/exe_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline: ALU opcodes, shifter types and
// the bit positions of the NZCV status word.
package arm_pkg;

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } exe_cmd_e;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_type_e;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU of the execute stage: result plus the NZCV word it would
// write. Logic/move ops and unknown opcodes pass the incoming C and V through.
module exe_alu
    import arm_pkg::*;
(
    input  logic [3:0]  exe_cmd,
    input  logic [31:0] rn,
    input  logic [31:0] val2,
    input  logic        carry_in,
    input  logic        overflow_in,
    output logic [31:0] result,
    output logic [3:0]  nzcv
);

    logic [32:0] sum;
    logic        c_flag;
    logic        v_flag;

    always_comb begin
        sum    = 33'd0;
        result = 32'd0;
        c_flag = carry_in;
        v_flag = overflow_in;
        case (exe_cmd)
            CMD_MOV: result = val2;
            CMD_MVN: result = ~val2;
            CMD_ADD, CMD_ADC: begin
                sum    = {1'b0, rn} + {1'b0, val2}
                         + {32'd0, (exe_cmd == CMD_ADC) & carry_in};
                result = sum[31:0];
                c_flag = sum[32];
                v_flag = (rn[31] == val2[31]) && (sum[31] != rn[31]);
            end
            CMD_SUB, CMD_SBC: begin
                // bit 32 of the 33-bit difference is the borrow; ARM C is its inverse
                sum    = {1'b0, rn} - {1'b0, val2}
                         - {32'd0, (exe_cmd == CMD_SBC) & ~carry_in};
                result = sum[31:0];
                c_flag = ~sum[32];
                v_flag = (rn[31] != val2[31]) && (sum[31] != rn[31]);
            end
            CMD_AND: result = rn & val2;
            CMD_ORR: result = rn | val2;
            CMD_EOR: result = rn ^ val2;
            default: result = 32'd0;
        endcase
        nzcv = {result[31], (result == 32'd0), c_flag, v_flag};
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, ALU, NZCV status register, branch target
// adder and the EXE/MEM pipeline register.
module exe_stage
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        s_update,
    input  logic        branch,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic        wb_en,
    input  logic [3:0]  exe_cmd,
    input  logic [31:0] val_rn,
    input  logic [31:0] val_rm,
    input  logic [31:0] pc,
    input  logic [23:0] signed_imm24,
    input  logic [3:0]  dest,
    input  logic        imm,
    input  logic [11:0] shift_operand,
    output logic [3:0]  status,
    output logic        branch_taken,
    output logic [31:0] branch_address,
    output logic        mem_wb_en,
    output logic        mem_mem_r_en,
    output logic        mem_mem_w_en,
    output logic [31:0] mem_alu_res,
    output logic [31:0] mem_val_rm,
    output logic [3:0]  mem_dest
);

    logic [31:0] val2;
    logic [31:0] imm_word;
    logic [63:0] imm_rot;
    logic [63:0] reg_rot;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic [3:0]  alu_nzcv;

    logic [3:0]  status_d, status_q;
    logic        wb_en_d, wb_en_q;
    logic        r_en_d, r_en_q;
    logic        w_en_d, w_en_q;
    logic [31:0] alu_res_d, alu_res_q;
    logic [31:0] val_rm_d, val_rm_q;
    logic [3:0]  dest_d, dest_q;

    // Rotates are taken from the low word of a doubled operand shifted right.
    always_comb begin
        shamt    = shift_operand[11:7];
        imm_word = {24'd0, shift_operand[7:0]};
        imm_rot  = {imm_word, imm_word} >> {shift_operand[11:8], 1'b0};
        reg_rot  = {val_rm, val_rm} >> shamt;
        val2     = val_rm;
        if (mem_r_en | mem_w_en) begin
            val2 = {20'd0, shift_operand};
        end else if (imm) begin
            val2 = imm_rot[31:0];
        end else begin
            case (shift_type_e'(shift_operand[6:5]))
                SHIFT_LSL: val2 = val_rm << shamt;
                SHIFT_LSR: val2 = val_rm >> shamt;
                SHIFT_ASR: val2 = 32'($signed(val_rm) >>> shamt);
                SHIFT_ROR: val2 = reg_rot[31:0];
                default:   val2 = val_rm;
            endcase
        end
    end

    exe_alu u_alu (
        .exe_cmd     (exe_cmd),
        .rn          (val_rn),
        .val2        (val2),
        .carry_in    (status_q[C_BIT]),
        .overflow_in (status_q[V_BIT]),
        .result      (alu_res),
        .nzcv        (alu_nzcv)
    );

    assign branch_taken   = branch;
    assign branch_address = pc + {{6{signed_imm24[23]}}, signed_imm24, 2'b00};

    always_comb begin
        status_d  = status_q;
        wb_en_d   = wb_en_q;
        r_en_d    = r_en_q;
        w_en_d    = w_en_q;
        alu_res_d = alu_res_q;
        val_rm_d  = val_rm_q;
        dest_d    = dest_q;
        if (!freeze) begin
            if (s_update) begin
                status_d = alu_nzcv;
            end
            wb_en_d   = wb_en;
            r_en_d    = mem_r_en;
            w_en_d    = mem_w_en;
            alu_res_d = alu_res;
            val_rm_d  = val_rm;
            dest_d    = dest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= 4'd0;
            wb_en_q   <= 1'b0;
            r_en_q    <= 1'b0;
            w_en_q    <= 1'b0;
            alu_res_q <= 32'd0;
            val_rm_q  <= 32'd0;
            dest_q    <= 4'd0;
        end else begin
            status_q  <= status_d;
            wb_en_q   <= wb_en_d;
            r_en_q    <= r_en_d;
            w_en_q    <= w_en_d;
            alu_res_q <= alu_res_d;
            val_rm_q  <= val_rm_d;
            dest_q    <= dest_d;
        end
    end

    assign status       = status_q;
    assign mem_wb_en    = wb_en_q;
    assign mem_mem_r_en = r_en_q;
    assign mem_mem_w_en = w_en_q;
    assign mem_alu_res  = alu_res_q;
    assign mem_val_rm   = val_rm_q;
    assign mem_dest     = dest_q;

endmodule
